reg_port_ctrl: RTL and testbench

Initiator for the CPU's single-port register file. Accepts operand-read requests (two source addresses) and write-back requests from the core, then serialises them onto the register file's one address/data/write port. It accounts for the register file's one-cycle registered read and returns both operands with a valid/ready response. It sits between decode/write-back and the register file, so it is the only block driving the register file port.

---
 rtl/reg_port_pkg.sv | 26 ++
 rtl/reg_port_ctrl.sv | 137 +++++++++++++
 tb/tb_reg_port_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_port_pkg.sv
// reg_port_pkg
//   Shared definitions for the register-file port controller: FSM state
//   encoding, default geometry of the register file, and the address
//   validity rule used by the controller and its bench.
package reg_port_pkg;

  localparam int DEF_NUM_REGS = 3;
  localparam int DEF_AW       = 4;
  localparam int DEF_DW       = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_RD_A  = 3'd2,
    S_RD_B  = 3'd3,
    S_CAP_B = 3'd4,
    S_RESP  = 3'd5
  } state_e;

  // An address is usable only if it names an implemented register.
  function automatic logic addr_valid(input int unsigned addr,
                                      input int unsigned num_regs = DEF_NUM_REGS);
    return addr < num_regs;
  endfunction

endpackage

// File: rtl/reg_port_ctrl.sv
// reg_port_ctrl
//   Sole initiator of the CPU's single-port register file. Serialises
//   write-backs and two-operand reads onto one address/data/write port and
//   absorbs the register file's one-cycle registered read latency.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      operand-read request handshake
//   req_addr_a/req_addr_b    source addresses
//   resp_valid/resp_ready    response handshake
//   resp_opa/resp_opb        operands (0 on error)
//   resp_err                 set when either source address is out of range
//   wb_valid/wb_ready        write-back handshake
//   wb_addr/wb_data          write-back destination and data
//   rf_addr/rf_wdata/rf_write  register file port (registered)
//   rf_rdata                 register file read data, one cycle after rf_addr
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | accept a write-back (priority) or an operand-read request
// WRITE   | rf_write asserted for one cycle with the latched address/data
// RD_A    | source A address presented to the register file
// RD_B    | source B address presented; A's data captured at cycle end
// CAP_B   | B's data captured at cycle end
// RESP    | response held until the consumer takes it
module reg_port_ctrl
  import reg_port_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr_a,
  input  logic [AW-1:0] req_addr_b,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_opa,
  output logic [DW-1:0] resp_opb,
  output logic          resp_err,
  input  logic          wb_valid,
  output logic          wb_ready,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_wdata,
  output logic          rf_write,
  input  logic [DW-1:0] rf_rdata
);

  state_e        state;
  logic [AW-1:0] addr_b_q;
  logic          in_idle;
  logic          a_ok;
  logic          b_ok;
  logic          wb_ok;

  assign in_idle = (state == S_IDLE) && !rst;

  // Write-back has priority so a read issued after a write sees new data.
  assign wb_ready  = in_idle;
  assign req_ready = in_idle && !wb_valid;

  assign a_ok  = addr_valid(32'(req_addr_a), NUM_REGS);
  assign b_ok  = addr_valid(32'(req_addr_b), NUM_REGS);
  assign wb_ok = addr_valid(32'(wb_addr), NUM_REGS);

  // rf_addr itself holds the latched write / source-A address, so the
  // register file port is driven purely from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr_b_q   <= '0;
      resp_valid <= 1'b0;
      resp_opa   <= '0;
      resp_opb   <= '0;
      resp_err   <= 1'b0;
      rf_addr    <= '0;
      rf_wdata   <= '0;
      rf_write   <= 1'b0;
    end else begin
      rf_write <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wb_valid) begin
            // Writes to unimplemented registers are accepted and dropped.
            if (wb_ok) begin
              rf_addr  <= wb_addr;
              rf_wdata <= wb_data;
              rf_write <= 1'b1;
              state    <= S_WRITE;
            end
          end else if (req_valid) begin
            if (a_ok && b_ok) begin
              rf_addr  <= req_addr_a;
              addr_b_q <= req_addr_b;
              state    <= S_RD_A;
            end else begin
              resp_opa   <= '0;
              resp_opb   <= '0;
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= S_RESP;
            end
          end
        end
        S_WRITE: state <= S_IDLE;
        S_RD_A: begin
          rf_addr <= addr_b_q;
          state   <= S_RD_B;
        end
        S_RD_B: begin
          resp_opa <= rf_rdata;
          state    <= S_CAP_B;
        end
        S_CAP_B: begin
          resp_opb   <= rf_rdata;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_port_ctrl.sv
module tb_reg_port_ctrl;
  import reg_port_pkg::*;

  localparam int NR = DEF_NUM_REGS;

  logic       clk;
  logic       rst;
  logic       req_valid, req_ready;
  logic [3:0] req_addr_a, req_addr_b;
  logic       resp_valid, resp_ready;
  logic [7:0] resp_opa, resp_opb;
  logic       resp_err;
  logic       wb_valid, wb_ready;
  logic [3:0] wb_addr;
  logic [7:0] wb_data;
  logic [3:0] rf_addr;
  logic [7:0] rf_wdata;
  logic       rf_write;
  logic [7:0] rf_rdata;

  reg_port_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_opa(resp_opa), .resp_opb(resp_opb), .resp_err(resp_err),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_write(rf_write),
    .rf_rdata(rf_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream register file: one port, registered read.
  logic [7:0] rf_mem [0:NR-1];
  initial for (int i = 0; i < NR; i++) rf_mem[i] = 8'h00;
  initial rf_rdata = 8'h00;
  always @(posedge clk) begin
    if (rf_write && rf_addr < 4'(NR)) rf_mem[rf_addr] <= rf_wdata;
    rf_rdata <= (rf_addr < 4'(NR)) ? rf_mem[rf_addr] : 8'h00;
  end

  // Reference architectural register contents.
  logic [7:0] ref_regs [0:NR-1];
  int n_chk  = 0;
  int n_fail = 0;
  int wr_pulses  = 0;
  int exp_pulses = 0;

  always @(negedge clk) if (rf_write) wr_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) check("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    logic ok;
    ok = addr_valid(32'(a));
    wb_valid = 1'b1; wb_addr = a; wb_data = d;
    @(negedge clk);
    check("wb_ready", wb_ready, 1);
    @(posedge clk); #1;
    wb_valid = 1'b0;
    @(negedge clk);
    check("wr_pulse", rf_write, ok);
    if (ok) begin
      check("wr_addr", rf_addr, a);
      check("wr_data", rf_wdata, d);
      ref_regs[a] = d;
      exp_pulses++;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [3:0] b, input int stall);
    logic       ok;
    logic [7:0] ea, eb;
    logic [3:0] addr_before;
    int         lat;
    ok = addr_valid(32'(a)) && addr_valid(32'(b));
    ea = ok ? ref_regs[a] : 8'h00;
    eb = ok ? ref_regs[b] : 8'h00;
    addr_before = rf_addr;
    req_valid = 1'b1; req_addr_a = a; req_addr_b = b;
    @(negedge clk);
    check("req_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(lat);
    check("rd_lat", lat, ok ? 4 : 1);
    check("opa", resp_opa, ea);
    check("opb", resp_opb, eb);
    check("err", resp_err, !ok);
    if (!ok) check("err_no_rf_access", rf_addr, addr_before);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", resp_valid, 1);
      check("stall_opa", resp_opa, ea);
      check("stall_req_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("resp_done", resp_valid, 0);
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1;
    req_valid = 0; req_addr_a = 0; req_addr_b = 0;
    resp_ready = 0; wb_valid = 0; wb_addr = 0; wb_data = 0;
    for (int i = 0; i < NR; i++) ref_regs[i] = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_wb_ready", wb_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_rf_write", rf_write, 0);
    check("rst_rf_addr", rf_addr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_opa", resp_opa, 0);
    check("rst_err", resp_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1);
    @(posedge clk); #1;

    // Write then read back.
    do_write(4'd1, 8'hA5);
    do_read(4'd1, 4'd0, 0);

    // Simultaneous write-back and read: write goes first.
    wb_valid = 1; wb_addr = 4'd2; wb_data = 8'h3C;
    req_valid = 1; req_addr_a = 4'd2; req_addr_b = 4'd2;
    @(negedge clk);
    check("both_req_ready", req_ready, 0);
    check("both_wb_ready", wb_ready, 1);
    @(posedge clk); #1;
    wb_valid = 0;
    ref_regs[2] = 8'h3C;
    exp_pulses++;
    @(negedge clk);
    check("both_rf_write", rf_write, 1);
    check("both_req_blocked", req_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("both_req_ready2", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0;
    wait_resp(lat);
    check("both_lat", lat, 4);
    check("both_opa", resp_opa, 8'h3C);
    check("both_opb", resp_opb, 8'h3C);
    resp_ready = 1; @(posedge clk); #1; resp_ready = 0;

    // Invalid read, invalid write.
    do_read(4'd3, 4'd1, 0);
    do_write(4'd3, 8'hFF);
    do_read(4'd0, 4'd1, 0);
    do_read(4'd2, 4'd2, 0);

    // Long stall in RESP with a write-back waiting.
    req_valid = 1; req_addr_a = 4'd1; req_addr_b = 4'd2;
    @(posedge clk); #1;
    req_valid = 0;
    wait_resp(lat);
    wb_valid = 1; wb_addr = 4'd0; wb_data = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", resp_valid, 1);
      check("hold_opa", resp_opa, ref_regs[1]);
      check("hold_opb", resp_opb, ref_regs[2]);
      check("hold_wb_ready", wb_ready, 0);
      check("hold_req_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    resp_ready = 1; @(posedge clk); #1; resp_ready = 0;
    @(negedge clk);
    check("post_resp_wb_ready", wb_ready, 1);
    @(posedge clk); #1;
    wb_valid = 0;
    ref_regs[0] = 8'h5A;
    exp_pulses++;
    @(negedge clk);
    check("post_resp_write", rf_write, 1);
    check("post_resp_addr", rf_addr, 0);
    @(posedge clk); #1;

    // Reset while in RD_B.
    req_valid = 1; req_addr_a = 4'd1; req_addr_b = 4'd2;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    check("mid_rst_valid", resp_valid, 0);
    check("mid_rst_opa", resp_opa, 0);
    check("mid_rst_opb", resp_opb, 0);
    check("mid_rst_rf_addr", rf_addr, 0);
    check("mid_rst_rf_write", rf_write, 0);
    @(negedge clk);
    check("mid_rst_req_ready", req_ready, 0);
    @(posedge clk); #1;
    rst = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("no_resp_after_rst", seen, 0);
    check("idle_after_rst", req_ready, 1);
    @(posedge clk); #1;

    // Randomised mix against the reference.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0)
        do_write(4'($urandom_range(0, 4)), 8'($urandom));
      else
        do_read(4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)),
                int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    check("wr_pulse_count", wr_pulses, exp_pulses);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
